// File: rtl/traffic_monitor.sv
// rtl/traffic_monitor.sv - lamp-bus conflict/sequence monitor with sticky fault and flash request
// Watches four 2-bit lamp codes, latches the first violation and holds flash until cleared.
module traffic_monitor #(
    parameter int TICK_DIV   = 50_000_000,
    parameter int MIN_YELLOW = 1,
    parameter int MAX_GREEN  = 5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] north,
    input  logic [1:0] east,
    input  logic [1:0] south,
    input  logic [1:0] west,
    input  logic       clear_fault,
    output logic       fault,
    output logic [2:0] fault_code,
    output logic [1:0] fault_dir,
    output logic       flash_req,
    output logic [7:0] cycle_count
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    typedef enum logic [1:0] {S_WAIT, S_RUN, S_FAULT} state_t;

    state_t          state;
    logic [1:0]      code [4];
    logic [1:0]      prev [4];
    logic [4:0]      dur  [4];
    logic [PW-1:0]   presc;

    logic            tick;
    logic            anychg;
    logic            seq_en;
    logic            north_on;
    logic [2:0]      n_green;
    logic [3:0]      chg, is_inv, is_skip, is_ys, is_gl;
    logic [5:0]      d_end;
    logic            hit;
    logic [2:0]      hit_code;
    logic [1:0]      hit_dir;

    assign code[0] = north;
    assign code[1] = east;
    assign code[2] = south;
    assign code[3] = west;

    assign tick     = (presc == PW'(TICK_DIV - 1));
    assign seq_en   = (state == S_RUN);
    assign north_on = (prev[0] == 2'b00 || prev[0] == 2'b01) && code[0] == 2'b10;

    always_comb begin
        chg     = '0;
        is_inv  = '0;
        is_skip = '0;
        is_ys   = '0;
        is_gl   = '0;
        n_green = '0;
        d_end   = '0;
        for (int d = 0; d < 4; d++) begin
            chg[d]     = (code[d] != prev[d]);
            d_end      = {1'b0, dur[d]} + {5'b0, tick};
            n_green    = n_green + {2'b0, code[d] == 2'b10};
            is_inv[d]  = (code[d] == 2'b11);
            is_skip[d] = (prev[d] == 2'b10) && (code[d] == 2'b00);
            is_ys[d]   = (prev[d] == 2'b01) && chg[d] && (d_end < 6'(MIN_YELLOW));
            is_gl[d]   = (code[d] == 2'b10) && !chg[d] && tick && (dur[d] == 5'(MAX_GREEN));
        end
        anychg = |chg;
    end

    // Scan from weakest to strongest so the last match is lowest code, then lowest dir.
    always_comb begin
        hit      = 1'b0;
        hit_code = 3'd0;
        hit_dir  = 2'd0;
        for (int d = 3; d >= 0; d--)
            if (seq_en && is_gl[d]) begin hit = 1'b1; hit_code = 3'd5; hit_dir = 2'(d); end
        for (int d = 3; d >= 0; d--)
            if (seq_en && is_ys[d]) begin hit = 1'b1; hit_code = 3'd4; hit_dir = 2'(d); end
        for (int d = 3; d >= 0; d--)
            if (seq_en && is_skip[d]) begin hit = 1'b1; hit_code = 3'd3; hit_dir = 2'(d); end
        for (int d = 3; d >= 0; d--)
            if (is_inv[d]) begin hit = 1'b1; hit_code = 3'd2; hit_dir = 2'(d); end
        if (n_green > 3'd1) begin
            hit      = 1'b1;
            hit_code = 3'd1;
            hit_dir  = 2'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_WAIT;
            fault       <= 1'b0;
            fault_code  <= 3'd0;
            fault_dir   <= 2'd0;
            flash_req   <= 1'b0;
            cycle_count <= 8'd0;
            presc       <= '0;
            for (int d = 0; d < 4; d++) begin
                prev[d] <= 2'b00;
                dur[d]  <= 5'd0;
            end
        end else begin
            for (int d = 0; d < 4; d++) begin
                prev[d] <= code[d];
                if (chg[d])
                    dur[d] <= 5'd0;
                else if (tick && dur[d] != 5'd31)
                    dur[d] <= dur[d] + 5'd1;
            end
            // Any lamp change realigns the tick to the controller's phase boundary.
            if (anychg || tick)
                presc <= '0;
            else
                presc <= presc + 1'b1;

            case (state)
                S_WAIT: begin
                    if (hit) begin
                        state      <= S_FAULT;
                        fault      <= 1'b1;
                        flash_req  <= 1'b1;
                        fault_code <= hit_code;
                        fault_dir  <= hit_dir;
                    end else if (n_green != 3'd0) begin
                        state <= S_RUN;
                        presc <= '0;
                        for (int d = 0; d < 4; d++) dur[d] <= 5'd0;
                    end
                end
                S_RUN: begin
                    if (north_on)
                        cycle_count <= cycle_count + 8'd1;
                    if (hit) begin
                        state      <= S_FAULT;
                        fault      <= 1'b1;
                        flash_req  <= 1'b1;
                        fault_code <= hit_code;
                        fault_dir  <= hit_dir;
                    end
                end
                S_FAULT: begin
                    if (clear_fault) begin
                        state      <= S_WAIT;
                        fault      <= 1'b0;
                        flash_req  <= 1'b0;
                        fault_code <= 3'd0;
                        fault_dir  <= 2'd0;
                        presc      <= '0;
                        for (int d = 0; d < 4; d++) dur[d] <= 5'd0;
                    end
                end
                default: state <= S_WAIT;
            endcase
        end
    end

endmodule

// File: tb/tb_traffic_monitor.sv
// tb/tb_traffic_monitor.sv - randomized and directed bench for traffic_monitor against a rule model
// The model tracks time since the last lamp change and per-direction tick counts as plain integers.
module tb_traffic_monitor;

    localparam int TD   = 10;
    localparam int MINY = 1;
    localparam int MAXG = 5;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [1:0] north = 2'b00, east = 2'b00, south = 2'b00, west = 2'b00;
    logic       clear_fault = 1'b0;
    logic       fault;
    logic [2:0] fault_code;
    logic [1:0] fault_dir;
    logic       flash_req;
    logic [7:0] cycle_count;

    traffic_monitor #(.TICK_DIV(TD), .MIN_YELLOW(MINY), .MAX_GREEN(MAXG)) dut (
        .clk         (clk),
        .reset       (reset),
        .north       (north),
        .east        (east),
        .south       (south),
        .west        (west),
        .clear_fault (clear_fault),
        .fault       (fault),
        .fault_code  (fault_code),
        .fault_dir   (fault_dir),
        .flash_req   (flash_req),
        .cycle_count (cycle_count)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // model: 0 wait, 1 run, 2 fault
    int m_state = 0, m_fault = 0, m_code = 0, m_dir = 0, m_count = 0, m_since = 0;
    int m_prev [4] = '{0, 0, 0, 0};
    int m_dur  [4] = '{0, 0, 0, 0};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input logic [1:0] n, input logic [1:0] e, input logic [1:0] s,
                       input logic [1:0] w, input logic clr, input logic rst);
        int  c [4];
        bit  chg [4];
        int  dn [4];
        bit  any, tick, clr_t, v;
        int  greens, fc, fd, sn;
        north = n; east = e; south = s; west = w; clear_fault = clr; reset = rst;
        c[0] = int'(n); c[1] = int'(e); c[2] = int'(s); c[3] = int'(w);
        if (rst) begin
            m_state = 0; m_fault = 0; m_code = 0; m_dir = 0; m_count = 0; m_since = 0;
            for (int d = 0; d < 4; d++) begin m_prev[d] = 0; m_dur[d] = 0; end
        end else begin
            any = 0; greens = 0;
            for (int d = 0; d < 4; d++) begin
                chg[d] = (c[d] != m_prev[d]);
                if (chg[d]) any = 1;
                if (c[d] == 2) greens++;
            end
            tick = ((m_since % TD) == TD - 1);
            fc = 0; fd = 0;
            if (m_state != 2)
                for (int k = 1; k <= 5; k++)
                    for (int d = 0; d < 4; d++) begin
                        case (k)
                            1: v = (d == 0) && (greens > 1);
                            2: v = (c[d] == 3);
                            3: v = (m_state == 1) && m_prev[d] == 2 && c[d] == 0;
                            4: v = (m_state == 1) && m_prev[d] == 1 && chg[d] &&
                                   (m_dur[d] + int'(tick)) < MINY;
                            default: v = (m_state == 1) && c[d] == 2 && !chg[d] && tick &&
                                         m_dur[d] == MAXG;
                        endcase
                        if (fc == 0 && v) begin fc = k; fd = d; end
                    end
            sn = any ? 0 : m_since + 1;
            for (int d = 0; d < 4; d++)
                dn[d] = chg[d] ? 0 : ((tick && m_dur[d] < 31) ? m_dur[d] + 1 : m_dur[d]);
            clr_t = 0;
            case (m_state)
                0: begin
                    if (fc != 0) begin m_state = 2; m_fault = 1; m_code = fc; m_dir = fd; end
                    else if (greens > 0) begin m_state = 1; clr_t = 1; end
                end
                1: begin
                    if ((m_prev[0] == 0 || m_prev[0] == 1) && c[0] == 2)
                        m_count = (m_count + 1) % 256;
                    if (fc != 0) begin m_state = 2; m_fault = 1; m_code = fc; m_dir = fd; end
                end
                default: begin
                    if (clr) begin
                        m_state = 0; m_fault = 0; m_code = 0; m_dir = 0; clr_t = 1;
                    end
                end
            endcase
            m_since = clr_t ? 0 : sn;
            for (int d = 0; d < 4; d++) begin
                m_dur[d]  = clr_t ? 0 : dn[d];
                m_prev[d] = c[d];
            end
        end
        @(posedge clk);
        #1;
        chk("outs", {17'd0, fault, fault_code, fault_dir, flash_req, cycle_count},
                    {17'd0, m_fault[0], m_code[2:0], m_dir[1:0], m_state == 2, m_count[7:0]});
    endtask

    task automatic hold_one(input int dir, input logic [1:0] val, input int k);
        logic [1:0] l [4];
        for (int i = 0; i < 4; i++) l[i] = (i == dir) ? val : 2'b00;
        repeat (k) cyc(l[0], l[1], l[2], l[3], 1'b0, 1'b0);
    endtask

    task automatic clear_all();
        cyc(2'b00, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0);
    endtask

    initial begin
        #1;
        cyc(2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b1);
        cyc(2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b1);
        chk("rst_fault", 32'(fault), 32'd0);
        chk("rst_flash", 32'(flash_req), 32'd0);
        chk("rst_count", 32'(cycle_count), 32'd0);

        // nominal controller: green 5 ticks, yellow 1 tick, round the four directions
        for (int cy = 0; cy < 3; cy++)
            for (int d = 0; d < 4; d++) begin
                hold_one(d, 2'b10, 5 * TD);
                hold_one(d, 2'b01, TD);
            end
        hold_one(0, 2'b10, 3);
        chk("nom_fault", 32'(fault), 32'd0);
        chk("nom_count", 32'(cycle_count), 32'd3);

        cyc(2'b10, 2'b10, 2'b00, 2'b00, 1'b0, 1'b0);
        chk("conf_fault", 32'(fault), 32'd1);
        chk("conf_code", 32'(fault_code), 32'd1);
        chk("conf_dir", 32'(fault_dir), 32'd0);
        chk("conf_flash", 32'(flash_req), 32'd1);
        repeat (20) cyc(2'b10, 2'b10, 2'b00, 2'b00, 1'b0, 1'b0);
        chk("conf_hold", 32'({fault, fault_code, fault_dir, flash_req}), 32'b1_001_00_1);
        clear_all();
        chk("clr_fault", 32'(fault), 32'd0);
        chk("clr_code", 32'(fault_code), 32'd0);
        chk("clr_count", 32'(cycle_count), 32'd3);

        hold_one(2, 2'b10, 3);
        cyc(2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0);
        chk("skip_code", 32'(fault_code), 32'd3);
        chk("skip_dir", 32'(fault_dir), 32'd2);
        clear_all();

        hold_one(1, 2'b10, 2);
        hold_one(1, 2'b01, 5);
        cyc(2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0);
        chk("ys_code", 32'(fault_code), 32'd4);
        chk("ys_dir", 32'(fault_dir), 32'd1);
        clear_all();

        hold_one(3, 2'b10, 6 * TD);
        chk("gl_before", 32'(fault), 32'd0);
        cyc(2'b00, 2'b00, 2'b00, 2'b10, 1'b0, 1'b0);
        chk("gl_code", 32'(fault_code), 32'd5);
        chk("gl_dir", 32'(fault_dir), 32'd3);
        clear_all();

        cyc(2'b00, 2'b00, 2'b00, 2'b11, 1'b0, 1'b0);
        chk("inv_code", 32'(fault_code), 32'd2);
        chk("inv_dir", 32'(fault_dir), 32'd3);
        clear_all();
        chk("inv_clr", 32'({fault, fault_code}), 32'd0);

        cyc(2'b10, 2'b10, 2'b00, 2'b11, 1'b0, 1'b0);
        chk("prio_code", 32'(fault_code), 32'd1);
        chk("prio_dir", 32'(fault_dir), 32'd0);
        clear_all();

        for (int seg = 0; seg < 80; seg++) begin
            logic [1:0] l [4];
            int r, len;
            for (int d = 0; d < 4; d++) begin
                r = $urandom_range(0, 15);
                l[d] = (r < 8) ? 2'b00 : (r < 11) ? 2'b01 : (r < 15) ? 2'b10 : 2'b11;
            end
            if ($urandom_range(0, 1) == 0) begin
                r = $urandom_range(0, 3);
                for (int d = 0; d < 4; d++) if (d != r) l[d] = 2'b00;
            end
            len = $urandom_range(1, 70);
            repeat (len)
                cyc(l[0], l[1], l[2], l[3], $urandom_range(0, 7) == 0, $urandom_range(0, 299) == 0);
        end

        cyc(2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b1);
        hold_one(0, 2'b10, 3);
        cyc(2'b10, 2'b10, 2'b00, 2'b00, 1'b0, 1'b1);
        chk("mrst_out", 32'({fault, fault_code, fault_dir, flash_req}), 32'd0);
        chk("mrst_count", 32'(cycle_count), 32'd0);
        cyc(2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
